// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
// Measures a sampled PWM waveform between consecutive rising edges and turns
// each correctly sized period back into the brightness code (high-cycle count)
// that produced it. A constant input is reported through an idle timeout as
// 0 or PERIOD.

module pwm_duty_meter #(
   parameter int PERIOD  = 16,
   parameter int DUTY_W  = 5,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_pwm,
   output logic [DUTY_W-1:0] o_duty,
   output logic              o_valid,
   output logic              o_err,
   output logic              o_locked
);

   typedef enum logic {
      ST_ACQ,
      ST_MEAS
   } state_t;

   localparam logic [CNT_W-1:0]  LP_PERIOD     = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0]  LP_IDLE_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  LP_ONE        = CNT_W'(1);
   localparam logic [DUTY_W-1:0] LP_FULL_DUTY  = DUTY_W'(PERIOD);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_prev;
   logic [CNT_W-1:0]  r_perCnt;
   logic [CNT_W-1:0]  r_hiCnt;
   logic [CNT_W-1:0]  r_idleCnt;
   state_t            r_state;
   logic [DUTY_W-1:0] r_duty;
   logic              r_valid;
   logic              r_err;
   logic              r_locked;

   logic              w_rise;
   logic              w_timeout;
   logic [DUTY_W-1:0] w_hiDuty;
   state_t            w_stateNext;
   logic [DUTY_W-1:0] w_dutyNext;
   logic              w_validNext;
   logic              w_errNext;
   logic              w_lockedNext;

   // A rising edge is seen when the synchronized sample is high and the one
   // before it was low; a timeout only counts if no edge arrives with it.
   assign w_rise    = r_sync2 & ~r_prev;
   assign w_timeout = (r_idleCnt == LP_IDLE_LAST) & ~w_rise;
   assign w_hiDuty  = DUTY_W'(r_hiCnt);

   // Two-flop synchronizer for the asynchronous PWM input, plus one more flop
   // holding the previous synchronized sample for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_pwm;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Period and high-time counters restart at 1 on each rising edge so that
   // the edge cycle itself is counted; both saturate rather than wrap. The
   // idle counter restarts on an edge or on a timeout.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_perCnt  <= '0;
         r_hiCnt   <= '0;
         r_idleCnt <= '0;
      end else if (w_rise) begin
         r_perCnt  <= LP_ONE;
         r_hiCnt   <= LP_ONE;
         r_idleCnt <= '0;
      end else begin
         if (r_perCnt != '1) begin
            r_perCnt <= r_perCnt + LP_ONE;
         end
         if (r_sync2 && (r_hiCnt != '1)) begin
            r_hiCnt <= r_hiCnt + LP_ONE;
         end
         if (w_timeout) begin
            r_idleCnt <= '0;
         end else begin
            r_idleCnt <= r_idleCnt + LP_ONE;
         end
      end
   end

   // State register and registered result outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_ACQ;
         r_duty   <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_duty   <= w_dutyNext;
         r_valid  <= w_validNext;
         r_err    <= w_errNext;
         r_locked <= w_lockedNext;
      end
   end

   // Next-state and result decode: an edge in ACQ only arms the measurement,
   // an edge in MEAS judges the finished period, and a timeout reports the
   // constant level and drops back to acquisition.
   always_comb begin
      w_stateNext  = r_state;
      w_dutyNext   = r_duty;
      w_validNext  = 1'b0;
      w_errNext    = 1'b0;
      w_lockedNext = r_locked;
      if (w_rise) begin
         case (r_state)
            ST_ACQ: begin
               w_stateNext = ST_MEAS;
            end
            ST_MEAS: begin
               if (r_perCnt == LP_PERIOD) begin
                  w_dutyNext   = w_hiDuty;
                  w_validNext  = 1'b1;
                  w_lockedNext = 1'b1;
               end else begin
                  w_errNext    = 1'b1;
                  w_lockedNext = 1'b0;
               end
            end
            default: begin
               w_stateNext = ST_ACQ;
            end
         endcase
      end else if (w_timeout) begin
         w_dutyNext   = r_sync2 ? LP_FULL_DUTY : '0;
         w_validNext  = 1'b1;
         w_lockedNext = 1'b0;
         w_stateNext  = ST_ACQ;
      end
   end

   assign o_duty   = r_duty;
   assign o_valid  = r_valid;
   assign o_err    = r_err;
   assign o_locked = r_locked;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter
// Drives PWM patterns (generator loopback, constant levels, wrong periods,
// reset mid-measurement) and compares every cycle against a timestamp-based
// reference that works from recorded input samples and rising-edge times.

module tb_pwm_duty_meter;

   localparam int PERIOD    = 16;
   localparam int DUTY_W    = 5;
   localparam int TIMEOUT   = 64;
   localparam int CNT_W     = 8;
   localparam int MAX_EDGES = 8192;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pwm;
   logic [DUTY_W-1:0] duty;
   logic              valid;
   logic              err;
   logic              locked;

   int vecCount = 0;
   int errCount = 0;

   // Reference model state: input sample per clock edge and event timestamps.
   bit pwmAt [0:MAX_EDGES-1];
   int edgeIdx     = -1;
   int validFrom   = MAX_EDGES;
   bit waitRelease = 1'b1;
   bit haveRef     = 1'b0;
   int lastRise    = 0;
   int lastClear   = 0;
   int expDuty     = 0;
   bit expValid    = 1'b0;
   bit expErr      = 1'b0;
   bit expLocked   = 1'b0;

   always #5 clk = ~clk;

   pwm_duty_meter #(
      .PERIOD (PERIOD),
      .DUTY_W (DUTY_W),
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_pwm   (pwm),
      .o_duty  (duty),
      .o_valid (valid),
      .o_err   (err),
      .o_locked(locked)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edgeIdx, observed, expected);
      end
   endtask

   // Input level as the meter sees it: samples taken before reset release
   // (or never taken) look like 0.
   function automatic bit smp(input int k);
      if (k < 0 || k < validFrom || k >= MAX_EDGES) return 1'b0;
      return pwmAt[k];
   endfunction

   task automatic resetModel();
      haveRef   = 1'b0;
      expDuty   = 0;
      expValid  = 1'b0;
      expErr    = 1'b0;
      expLocked = 1'b0;
   endtask

   // Result the meter registers at clock edge d. The level it acts on at edge
   // d is the input captured two edges earlier; a period is the edge distance
   // between two accepted rising edges and the duty is the number of high
   // samples inside it.
   task automatic modelStep();
      int d;
      bit s;
      bit prev;
      int per;
      int hi;
      edgeIdx++;
      d = edgeIdx;
      if (d < MAX_EDGES) pwmAt[d] = pwm;
      expValid = 1'b0;
      expErr   = 1'b0;
      if (!rst_n) begin
         resetModel();
         waitRelease = 1'b1;
         validFrom   = MAX_EDGES;
         return;
      end
      if (waitRelease) begin
         validFrom   = d;
         lastClear   = d - 1;
         waitRelease = 1'b0;
      end
      s    = smp(d - 2);
      prev = smp(d - 3);
      if (s && !prev) begin
         if (haveRef) begin
            per = d - lastRise;
            hi  = 0;
            for (int k = lastRise; k < d; k++) hi += int'(smp(k - 2));
            if (per == PERIOD) begin
               expDuty   = hi;
               expValid  = 1'b1;
               expLocked = 1'b1;
            end else begin
               expErr    = 1'b1;
               expLocked = 1'b0;
            end
         end
         haveRef   = 1'b1;
         lastRise  = d;
         lastClear = d;
      end else if (d - lastClear == TIMEOUT) begin
         expDuty   = s ? PERIOD : 0;
         expValid  = 1'b1;
         expLocked = 1'b0;
         haveRef   = 1'b0;
         lastClear = d;
      end
   endtask

   // Drive one input cycle, advance the model at the edge, compare at negedge.
   task automatic applyStimulus(input bit v);
      pwm = v;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("valid",  int'(valid),  int'(expValid));
      checkOutput("err",    int'(err),    int'(expErr));
      checkOutput("duty",   int'(duty),   expDuty);
      checkOutput("locked", int'(locked), int'(expLocked));
   endtask

   task automatic runPwm(input int period, input int high, input int nPeriods);
      for (int p = 0; p < nPeriods; p++) begin
         for (int c = 0; c < period; c++) applyStimulus(c < high);
      end
   endtask

   task automatic runLevel(input bit v, input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(v);
   endtask

   initial begin
      pwm   = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("rstValid0",  int'(valid),  0);
      checkOutput("rstErr0",    int'(err),    0);
      checkOutput("rstDuty0",   int'(duty),   0);
      checkOutput("rstLocked0", int'(locked), 0);
      runLevel(1'b0, 3);
      rst_n = 1'b1;

      $display("[TB] generator loopback at brightness 5");
      runPwm(PERIOD, 5, 6);
      checkOutput("b5Duty",   int'(duty),   5);
      checkOutput("b5Locked", int'(locked), 1);

      $display("[TB] brightness step 3 -> 12");
      runPwm(PERIOD, 3, 4);
      runPwm(PERIOD, 12, 4);
      checkOutput("b12Duty", int'(duty), 12);

      $display("[TB] random brightness codes");
      for (int i = 0; i < 8; i++) begin
         runPwm(PERIOD, int'($urandom_range(0, PERIOD)), 4);
      end

      $display("[TB] constant low, then constant high");
      runLevel(1'b0, 140);
      checkOutput("lowDuty",   int'(duty),   0);
      checkOutput("lowLocked", int'(locked), 0);
      runLevel(1'b1, 140);
      checkOutput("highDuty",   int'(duty),   PERIOD);
      checkOutput("highLocked", int'(locked), 0);

      $display("[TB] restart at brightness 9");
      runLevel(1'b0, 4);
      runPwm(PERIOD, 9, 4);
      checkOutput("b9Duty", int'(duty), 9);

      $display("[TB] wrong period 20, high 7");
      runPwm(20, 7, 5);
      checkOutput("p20Duty",   int'(duty),   9);
      checkOutput("p20Locked", int'(locked), 0);

      $display("[TB] reset mid-period while locked at 7");
      runPwm(PERIOD, 7, 4);
      for (int c = 0; c < 10; c++) applyStimulus(c < 7);
      rst_n = 1'b0;
      #1;
      checkOutput("rstValid",  int'(valid),  0);
      checkOutput("rstErr",    int'(err),    0);
      checkOutput("rstDuty",   int'(duty),   0);
      checkOutput("rstLocked", int'(locked), 0);
      applyStimulus(1'b0);
      rst_n = 1'b1;
      for (int c = 11; c < PERIOD; c++) applyStimulus(c < 7);
      runPwm(PERIOD, 7, 4);
      checkOutput("b7Duty",   int'(duty),   7);
      checkOutput("b7Locked", int'(locked), 1);

      $display("[TB] random periods and high times");
      for (int i = 0; i < 6; i++) begin
         int per;
         per = int'($urandom_range(10, 24));
         runPwm(per, int'($urandom_range(0, per)), 4);
      end
      runPwm(PERIOD, 11, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
